// File: rtl/uart_rx_fifo.sv
// Receive FIFO between uart_rx and the CPU data port: captures one byte per
// rx_data_ready assertion, pops one byte per CPU read, and flags dropped bytes.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int INT_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    output logic              rx_clear,
    input  logic              rd_req,
    output logic [7:0]        dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clear,
    output logic              int_req
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_CLR = 1'b1
    } state_t;

    state_t            state_q;
    logic              rx_clear_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q, overrun_q, int_req_q;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        mem_q [DEPTH];

    logic push_s, pop_s, wr_en_s, drop_s;

    // Push/pop qualification, next-state pointers, count and show-ahead head byte
    always_comb begin
        push_s   = 1'b0;
        pop_s    = 1'b0;
        wr_en_s  = 1'b0;
        drop_s   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = 8'h00;

        if (state_q == IDLE && rx_data_ready) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        if (rd_req && !rd_req_q && !empty_q) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // A full FIFO still accepts a byte when the same edge frees a slot
        if (push_s && (!full_q || pop_s)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
        drop_s = push_s && !wr_en_s;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // The new head may be the byte being written on this same edge
        if (count_d == (ADDR_W+1)'(0)) begin
            dout_d = 8'h00;
        end else if (wr_en_s && rd_ptr_d == wr_ptr_q) begin
            dout_d = rx_data;
        end else begin
            dout_d = mem_q[rd_ptr_d];
        end
    end

    // Capture FSM, pointers, flags and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rx_clear_q <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            int_req_q  <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_data_ready) begin
                        state_q    <= WAIT_CLR;
                        rx_clear_q <= 1'b1;
                    end
                end
                WAIT_CLR: begin
                    if (!rx_data_ready) begin
                        state_q    <= IDLE;
                        rx_clear_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_clear_q <= 1'b0;
                end
            endcase

            rd_req_q  <= rd_req;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= (count_d == (ADDR_W+1)'(0));
            full_q    <= (count_d == (ADDR_W+1)'(DEPTH));
            int_req_q <= (count_d >= (ADDR_W+1)'(INT_LEVEL));
            dout_q    <= dout_d;

            if (drop_s) begin
                overrun_q <= 1'b1;
            end else if (ovr_clear) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Storage array, deliberately left without reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_clear = rx_clear_q;
    assign dout     = dout_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign int_req  = int_req_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Placement: between uart_rx (sys_clk domain) and the Z80 I/O data-register read path; buffers received bytes so the CPU can fall behind the serial line.

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 4..256).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have parameter INT_LEVEL, default 1, fill count at or above which int_req asserts (1..DEPTH).
REQ-004 SHALL use one clock and a synchronous active-low reset: clk and reset_n.
REQ-005 clk  input  1  system clock (sys_clk, 27 MHz); all state changes on rising edge.
REQ-006 reset_n  input  1  synchronous active-low reset.
REQ-007 rx_data  input  8  byte from uart_rx; valid while rx_data_ready=1.
REQ-008 rx_data_ready  input  1  uart_rx byte-available level.
REQ-009 rx_clear  output  1  handshake to uart_rx; held 1 until rx_data_ready falls.
REQ-010 rd_req  input  1  level; high while the CPU reads the data port; rising edge pops one byte.
REQ-011 dout  output  8  head-of-FIFO byte (show-ahead); 8'h00 when empty.
REQ-012 empty  output  1  count==0.
REQ-013 full  output  1  count==DEPTH.
REQ-014 count  output  ADDR_W+1  current fill level.
REQ-015 overrun  output  1  sticky flag: a received byte was dropped.
REQ-016 ovr_clear  input  1  single-cycle pulse; clears overrun.
REQ-017 int_req  output  1  registered, 1 when count>=INT_LEVEL.

Function
REQ-018 Capture FSM SHALL have states IDLE and WAIT_CLR.
REQ-019 In IDLE with rx_data_ready=1 at a clock edge, the FSM SHALL push rx_data (subject to REQ-022), set rx_clear<=1, and go to WAIT_CLR.
REQ-020 In WAIT_CLR, the FSM SHALL hold rx_clear=1 and push nothing; when rx_data_ready=0 it SHALL set rx_clear<=0 and go to IDLE.
REQ-021 Each rx_data_ready assertion SHALL push exactly one byte.
REQ-022 A push SHALL write mem[wr_ptr]<=rx_data and increment wr_ptr modulo DEPTH if !full, or if full and a pop occurs in the same cycle.
REQ-023 A push when full with no simultaneous pop SHALL drop the byte, leave pointers and count unchanged, and set overrun<=1.
REQ-024 rd_req SHALL be registered (rd_req_d). A pop event SHALL be rd_req & ~rd_req_d, so one pop per CPU read regardless of read length.
REQ-025 A pop when empty SHALL be ignored, with no pointer or count change and no error flag.
REQ-026 A pop when not empty SHALL increment rd_ptr modulo DEPTH.
REQ-027 dout SHALL equal mem[rd_ptr] when !empty, else 8'h00; the pushed byte SHALL be visible on dout the cycle after its push edge.
REQ-028 Count arithmetic: push-only +1; pop-only -1; push+pop with count in 1..DEPTH SHALL leave count unchanged; push+pop with count 0 is +1 (pop ignored).
REQ-029 Pointers SHALL be ADDR_W bits and wrap DEPTH-1 -> 0 naturally; empty/full SHALL derive from count, not from pointer compare.
REQ-030 overrun SHALL clear on ovr_clear=1; if ovr_clear and a new drop occur in the same cycle, overrun SHALL remain 1.
REQ-031 int_req SHALL be registered from the next-state count, so it reflects a push or pop on the same edge.

Reset
REQ-032 With reset_n=0 at a clock edge: state=IDLE, rx_clear=0, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0, int_req=0, rd_req_d=0, dout=8'h00; memory contents SHALL be don't-care.
REQ-033 Reset SHALL take priority over any push, pop or clear in the same cycle. A byte mid-handshake at reset SHALL be discarded; after release, a still-high rx_data_ready SHALL be captured as a new byte.

Verification
REQ-034 Single byte: rx_data=8'h41, rx_data_ready high 3 cycles -> rx_clear=1 one cycle after capture; rx_clear stays 1 until ready falls; then count=1, dout=8'h41, int_req=1.
REQ-035 Long read: rd_req high 10 cycles with 2 bytes queued -> exactly one pop, count 2->1, dout advances to the second byte.
REQ-036 Fill and overflow (DEPTH=16): push 8'h00..8'h10 (17 bytes) -> full=1, count=16, overrun=1, dout=8'h00; pop 16 times -> bytes 8'h00..8'h0F in order, then empty=1.
REQ-037 Wrap: with wr_ptr=rd_ptr=14, push 4 bytes and pop 4 bytes -> pointers wrap to 2, data order preserved.
REQ-038 Simultaneous events: when full, push+pop on the same edge -> count stays 16, no overrun; when empty, push+pop on the same edge -> count=1; ovr_clear coincident with a drop -> overrun stays 1.
REQ-039 Reset mid-handshake: reset_n=0 while in WAIT_CLR with count=5 -> count=0, rx_clear=0, int_req=0 on the next edge.
